// File: rtl/dmem_arbiter_pkg.sv
// Shared owner-state type and default sizing for the data-memory arbiter.
package dmem_arbiter_pkg;

    localparam int unsigned DefaultStarveLimit = 8;
    localparam int unsigned DefaultAw          = 32;
    localparam int unsigned DataW              = 32;

    // Owner of the memory port in the previous cycle.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_OWN = 2'd1,
        EXT_OWN = 2'd2
    } ownerState_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Pipeline, external-requester and data-memory signals of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface dmem_arbiter_if #(
    parameter int unsigned AW = dmem_arbiter_pkg::DefaultAw
);
    localparam int unsigned DW = dmem_arbiter_pkg::DataW;

    // Pipeline MEM-stage port
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;

    // External loader/debug port
    logic          ext_req;
    logic          ext_we;
    logic          ext_lock;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata;
    logic          ext_gnt;
    logic          ext_rvalid;
    logic [DW-1:0] ext_rdata;

    // Combinational-read data memory
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_re;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  ext_req, ext_we, ext_lock, ext_addr, ext_wdata,
        output ext_gnt, ext_rvalid, ext_rdata,
        output mem_addr, mem_wdata, mem_we, mem_re,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output ext_req, ext_we, ext_lock, ext_addr, ext_wdata,
        input  ext_gnt, ext_rvalid, ext_rdata,
        input  mem_addr, mem_wdata, mem_we, mem_re,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_arb_starve_cnt.sv
// Counts consecutive denied external-request cycles and flags when the external
// requester has waited STARVE_LIMIT cycles and must be granted.
module dmem_arb_starve_cnt
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = DefaultStarveLimit
) (
    input  logic clk,
    input  logic reset,
    input  logic extReq,
    input  logic extGrant,
    output logic starveHit_c
);

    localparam int unsigned CntW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [CntW-1:0] waitCnt;

    // Saturating wait counter; any grant or a dropped request restarts the wait.
    always_ff @(posedge clk) begin
        if (reset || !extReq || extGrant) begin
            waitCnt <= '0;
        end else if (waitCnt != CntW'(STARVE_LIMIT)) begin
            waitCnt <= waitCnt + CntW'(1);
        end
    end

    assign starveHit_c = (waitCnt == CntW'(STARVE_LIMIT));

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter between the pipeline MEM stage and an external port.
// Optional starvation guard for the external port: define DMEM_ARB_STARVE_GUARD_EN.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = DefaultStarveLimit,
    parameter int unsigned AW           = DefaultAw
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);

    ownerState_t      state;
    ownerState_t      nextState;
    ownerState_t      effState;
    logic             cpuGrant;
    logic             extGrant;
    logic             lockHold;
    logic             forceExt;
    logic             extRdBeat;
    logic             extRvalidQ;
    logic [DataW-1:0] extRdataQ;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    logic starveHit_c;

    dmem_arb_starve_cnt #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) uStarveCnt (
        .clk         (clk),
        .reset       (reset),
        .extReq      (bus.ext_req),
        .extGrant    (extGrant),
        .starveHit_c (starveHit_c)
    );

    // Only a live request can be forced through; reset sees a freshly idle arbiter.
    assign forceExt = ~reset & bus.ext_req & starveHit_c;
`else
    localparam int unsigned unusedStarveLimit = STARVE_LIMIT;

    assign forceExt = 1'b0;
`endif

    // Owner register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Grant decision and next owner
    always_comb begin
        cpuGrant  = 1'b0;
        extGrant  = 1'b0;
        nextState = IDLE;
        effState  = reset ? IDLE : state;
        lockHold  = (effState == EXT_OWN) && bus.ext_lock && bus.ext_req;

        if (lockHold || forceExt) begin
            extGrant = 1'b1;
        end else if (bus.cpu_req) begin
            cpuGrant = 1'b1;
        end else if (bus.ext_req) begin
            extGrant = 1'b1;
        end

        if (cpuGrant) begin
            nextState = CPU_OWN;
        end else if (extGrant) begin
            nextState = EXT_OWN;
        end
    end

    // Memory port steering; an ungranted cycle presents a quiet, all-zero bus.
    always_comb begin
        bus.mem_addr  = AW'(0);
        bus.mem_wdata = '0;
        bus.mem_we    = 1'b0;
        bus.mem_re    = 1'b0;
        if (cpuGrant) begin
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
            bus.mem_we    = bus.cpu_we;
            bus.mem_re    = ~bus.cpu_we;
        end else if (extGrant) begin
            bus.mem_addr  = bus.ext_addr;
            bus.mem_wdata = bus.ext_wdata;
            bus.mem_we    = bus.ext_we;
            bus.mem_re    = ~bus.ext_we;
        end
    end

    assign bus.cpu_stall = bus.cpu_req & ~cpuGrant;
    assign bus.cpu_rdata = cpuGrant ? bus.mem_rdata : '0;
    assign bus.ext_gnt   = extGrant;

    assign extRdBeat = extGrant & ~bus.ext_we;

    // External read data returns one cycle after its beat; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            extRvalidQ <= 1'b0;
            extRdataQ  <= '0;
        end else begin
            extRvalidQ <= extRdBeat;
            if (extRdBeat) begin
                extRdataQ <= bus.mem_rdata;
            end
        end
    end

    assign bus.ext_rvalid = extRvalidQ;
    assign bus.ext_rdata  = extRdataQ;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter; external read returns are scoreboarded.
// Covers the DMEM_ARB_STARVE_GUARD_EN build when that macro is defined.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int unsigned AW    = 32;
    localparam int unsigned LIMIT = 8;

    typedef struct {
        logic        v;
        logic [31:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    exp_t mon;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(AW)) bus();

    dmem_arbiter #(
        .STARVE_LIMIT (LIMIT),
        .AW           (AW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [31:0] memModel(input logic [31:0] a);
        if (a == 32'h20) return 32'hDEADBEEF;
        return {a[15:0], 16'hC0DE} ^ 32'h1234_0000;
    endfunction

    assign bus.mem_rdata = memModel(bus.mem_addr);

    // Scoreboard: one entry per cycle describing the registered ext read return.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon = sb.pop_front();
            total++;
            if (bus.ext_rvalid !== mon.v) begin
                bad++;
                $display("FAIL sb_rvalid: got %b want %b at %0t", bus.ext_rvalid, mon.v, $time);
            end
            if (mon.v) begin
                total++;
                if (bus.ext_rdata !== mon.d) begin
                    bad++;
                    $display("FAIL sb_rdata: got %h want %h at %0t", bus.ext_rdata, mon.d, $time);
                end
            end
        end
    end

    task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                         input logic er, input logic ew, input logic el,
                         input logic [31:0] ea, input logic [31:0] ed);
        bus.cpu_req   = cr;
        bus.cpu_we    = cw;
        bus.cpu_addr  = ca;
        bus.cpu_wdata = cd;
        bus.ext_req   = er;
        bus.ext_we    = ew;
        bus.ext_lock  = el;
        bus.ext_addr  = ea;
        bus.ext_wdata = ed;
        @(negedge clk);
    endtask

    task automatic advance(input logic v, input logic [31:0] d);
        exp_t e;
        @(posedge clk);
        e.v = v;
        e.d = d;
        sb.push_back(e);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        advance(0, 0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        total++;
        if (bus.mem_we !== 1'b0 || bus.mem_re !== 1'b0 || bus.ext_gnt !== 1'b0) begin
            bad++;
            $display("FAIL rst_idle: got we=%b re=%b gnt=%b want 0 0 0", bus.mem_we, bus.mem_re, bus.ext_gnt);
        end
        advance(0, 0);
        // Priority logic stays live in reset, but the read return is dropped.
        drive(0, 0, 0, 0, 1, 0, 0, 32'h20, 0);
        total++;
        if (bus.ext_gnt !== 1'b1 || bus.mem_re !== 1'b1 || bus.mem_addr !== 32'h20) begin
            bad++;
            $display("FAIL rst_comb: got gnt=%b re=%b addr=%h want 1 1 20", bus.ext_gnt, bus.mem_re, bus.mem_addr);
        end
        advance(0, 0);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        total++;
        if (bus.ext_rdata !== 32'h0 || bus.ext_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL rst_regs: got rdata=%h rvalid=%b want 0 0", bus.ext_rdata, bus.ext_rvalid);
        end
        advance(0, 0);
    endtask

    task automatic test_contention();
        drive(1, 0, 32'h10, 0, 1, 0, 0, 32'h20, 0);
        total++;
        if (bus.cpu_stall !== 1'b0 || bus.ext_gnt !== 1'b0 || bus.mem_addr !== 32'h10 || bus.mem_re !== 1'b1) begin
            bad++;
            $display("FAIL cont_rd: got stall=%b gnt=%b addr=%h re=%b want 0 0 10 1",
                     bus.cpu_stall, bus.ext_gnt, bus.mem_addr, bus.mem_re);
        end
        total++;
        if (bus.cpu_rdata !== memModel(32'h10)) begin
            bad++;
            $display("FAIL cont_cpu_rdata: got %h want %h", bus.cpu_rdata, memModel(32'h10));
        end
        advance(0, 0);
        drive(1, 1, 32'h44, 32'hCAFE0001, 1, 1, 0, 32'h48, 32'h11111111);
        total++;
        if (bus.mem_we !== 1'b1 || bus.mem_re !== 1'b0 || bus.mem_addr !== 32'h44 ||
            bus.mem_wdata !== 32'hCAFE0001 || bus.ext_gnt !== 1'b0) begin
            bad++;
            $display("FAIL cont_wr: got we=%b re=%b addr=%h wdata=%h gnt=%b want 1 0 44 cafe0001 0",
                     bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata, bus.ext_gnt);
        end
        advance(0, 0);
        idle();
    endtask

    task automatic test_ext_read();
        drive(0, 0, 0, 0, 1, 0, 0, 32'h20, 0);
        total++;
        if (bus.ext_gnt !== 1'b1 || bus.mem_re !== 1'b1 || bus.mem_addr !== 32'h20 ||
            bus.cpu_stall !== 1'b0 || bus.cpu_rdata !== 32'h0) begin
            bad++;
            $display("FAIL ext_rd: got gnt=%b re=%b addr=%h stall=%b crd=%h want 1 1 20 0 0",
                     bus.ext_gnt, bus.mem_re, bus.mem_addr, bus.cpu_stall, bus.cpu_rdata);
        end
        advance(1, 32'hDEADBEEF);
        drive(0, 0, 0, 0, 1, 1, 0, 32'h30, 32'h55);
        total++;
        if (bus.ext_gnt !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_wdata !== 32'h55 || bus.mem_addr !== 32'h30) begin
            bad++;
            $display("FAIL ext_wr: got gnt=%b we=%b wdata=%h addr=%h want 1 1 55 30",
                     bus.ext_gnt, bus.mem_we, bus.mem_wdata, bus.mem_addr);
        end
        advance(0, 0);
        idle();
    endtask

    task automatic test_lock();
        logic [31:0] a;
        drive(0, 0, 0, 0, 1, 0, 1, 32'h40, 0);
        total++;
        if (bus.ext_gnt !== 1'b1) begin
            bad++;
            $display("FAIL lock_first: got gnt=%b want 1", bus.ext_gnt);
        end
        advance(1, memModel(32'h40));
        for (int i = 0; i < 3; i++) begin
            a = 32'h44 + 32'(4 * i);
            drive(1, 0, 32'h10, 0, 1, 0, 1, a, 0);
            total++;
            if (bus.cpu_stall !== 1'b1 || bus.ext_gnt !== 1'b1 || bus.mem_addr !== a || bus.cpu_rdata !== 32'h0) begin
                bad++;
                $display("FAIL lock_beat%0d: got stall=%b gnt=%b addr=%h crd=%h want 1 1 %h 0",
                         i, bus.cpu_stall, bus.ext_gnt, bus.mem_addr, bus.cpu_rdata, a);
            end
            advance(1, memModel(a));
        end
        drive(1, 0, 32'h10, 0, 1, 0, 0, 32'h50, 0);
        total++;
        if (bus.cpu_stall !== 1'b0 || bus.ext_gnt !== 1'b0 || bus.mem_addr !== 32'h10) begin
            bad++;
            $display("FAIL lock_release: got stall=%b gnt=%b addr=%h want 0 0 10",
                     bus.cpu_stall, bus.ext_gnt, bus.mem_addr);
        end
        advance(0, 0);
        idle();
    endtask

    task automatic test_lock_drop();
        drive(0, 0, 0, 0, 1, 0, 1, 32'h60, 0);
        advance(1, memModel(32'h60));
        drive(1, 0, 32'h14, 0, 0, 0, 1, 32'h64, 0);
        total++;
        if (bus.ext_gnt !== 1'b0 || bus.cpu_stall !== 1'b0 || bus.mem_addr !== 32'h14) begin
            bad++;
            $display("FAIL drop_beat: got gnt=%b stall=%b addr=%h want 0 0 14",
                     bus.ext_gnt, bus.cpu_stall, bus.mem_addr);
        end
        advance(0, 0);
        // Ownership was lost, so a re-raised locked request no longer beats the cpu.
        drive(1, 0, 32'h14, 0, 1, 0, 1, 32'h64, 0);
        total++;
        if (bus.ext_gnt !== 1'b0 || bus.cpu_stall !== 1'b0) begin
            bad++;
            $display("FAIL drop_owner: got gnt=%b stall=%b want 0 0", bus.ext_gnt, bus.cpu_stall);
        end
        advance(0, 0);
        idle();
    endtask

    task automatic test_reset_mid_lock();
        drive(0, 0, 0, 0, 1, 0, 1, 32'h68, 0);
        advance(1, memModel(32'h68));
        reset = 1'b1;
        drive(1, 0, 32'h18, 0, 1, 0, 1, 32'h6C, 0);
        total++;
        if (bus.ext_gnt !== 1'b0 || bus.cpu_stall !== 1'b0 || bus.mem_addr !== 32'h18) begin
            bad++;
            $display("FAIL rstlock_comb: got gnt=%b stall=%b addr=%h want 0 0 18",
                     bus.ext_gnt, bus.cpu_stall, bus.mem_addr);
        end
        advance(0, 0);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        total++;
        if (bus.ext_rdata !== 32'h0) begin
            bad++;
            $display("FAIL rstlock_rdata: got %h want 0", bus.ext_rdata);
        end
        advance(0, 0);
    endtask

    task automatic test_starve();
        logic expG;
`ifdef DMEM_ARB_STARVE_GUARD_EN
        // Two full rounds: the second proves the wait count restarted after the forced grant.
        for (int r = 0; r < 2; r++) begin
            for (int c = 1; c <= int'(LIMIT) + 1; c++) begin
                expG = (c == int'(LIMIT) + 1);
                drive(1, 0, 32'h10, 0, 1, 0, 0, 32'h20, 0);
                total++;
                if (bus.ext_gnt !== expG || bus.cpu_stall !== expG) begin
                    bad++;
                    $display("FAIL starve_r%0d_c%0d: got gnt=%b stall=%b want %b %b",
                             r, c, bus.ext_gnt, bus.cpu_stall, expG, expG);
                end
                advance(expG, 32'hDEADBEEF);
            end
        end
`else
        expG = 1'b0;
        for (int c = 0; c < 100; c++) begin
            drive(1, 0, 32'h10, 0, 1, 0, 0, 32'h20, 0);
            total++;
            if (bus.ext_gnt !== expG) begin
                bad++;
                $display("FAIL nostarve_c%0d: got gnt=%b want %b", c, bus.ext_gnt, expG);
            end
            advance(0, 0);
        end
`endif
        idle();
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_contention();
        test_ext_read();
        test_lock();
        test_lock_drop();
        test_reset_mid_lock();
        test_starve();
        @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d entries want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
- REQ-001: Parameter STARVE_LIMIT, default 8: consecutive denied external-request cycles before a forced external grant.
- REQ-002: Parameter AW, default 32: address width.
- REQ-003: clk  in  1  sole clock; all state updates on the rising edge.
- REQ-004: reset  in  1  synchronous, active-high reset.
- REQ-005: cpu_req  in  1  pipeline MEM-stage access this cycle (MemRead | MemWrite).
- REQ-006: cpu_we  in  1  pipeline write (1) / read (0).
- REQ-007: cpu_addr  in  AW  pipeline address; cpu_wdata  in  32  pipeline write data.
- REQ-008: cpu_rdata  out  32  pipeline read data; cpu_stall  out  1  pipeline access not granted, so hold PC, IF/ID, ID/EX and EX/MEM.
- REQ-009: ext_req  in  1  external loader/debug request; ext_we  in  1  external write; ext_lock  in  1  keep ownership for the next beat.
- REQ-010: ext_addr  in  AW  external address; ext_wdata  in  32  external write data.
- REQ-011: ext_gnt  out  1  external beat accepted this cycle; ext_rvalid  out  1  ext_rdata valid; ext_rdata  out  32  external read data.
- REQ-012: mem_addr  out  AW; mem_wdata  out  32; mem_we  out  1; mem_re  out  1; mem_rdata  in  32  (combinational-read data memory).

Function
- REQ-013: FSM states are IDLE, CPU_OWN and EXT_OWN; the state register holds the owner of the previous cycle.
- REQ-014: A grant is decided combinationally every cycle, in this priority order: (a) state EXT_OWN with ext_lock=1 and ext_req=1 grants ext; (b) forced-starve condition grants ext; (c) cpu_req=1 grants cpu; (d) ext_req=1 grants ext; (e) otherwise no grant.
- REQ-015: Next state is CPU_OWN on a cpu grant, EXT_OWN on an ext grant, IDLE on no grant.
- REQ-016: The granted requester's addr, wdata and we drive the mem_* outputs. mem_re = granted & ~we. With no grant, mem_we=0, mem_re=0, mem_addr=0 and mem_wdata=0.
- REQ-017: cpu_stall = cpu_req & ~cpu_grant, combinational, with zero-cycle latency.
- REQ-018: cpu_rdata = mem_rdata whenever the cpu holds the grant, else 0.
- REQ-019: ext_gnt = ext grant, combinational. An ext beat completes in the cycle ext_gnt=1.
- REQ-020: For a granted ext read, ext_rdata is registered from mem_rdata and ext_rvalid pulses 1 in the following cycle. ext_rvalid is 0 after ext writes and idle cycles.
- REQ-021: A lock chain ends when ext_lock=0 or ext_req=0; ownership then returns to priority evaluation in the same cycle.
- REQ-022: When cpu_req and ext_req are both high, with no lock and no starvation, the cpu wins and ext waits without error.
- REQ-023: When ext_req drops mid-lock, the state leaves EXT_OWN next cycle and no ext_rvalid is generated for the dropped beat.

Reset
- REQ-024: While reset=1 the following hold at the next edge: state=IDLE, starve counter=0, ext_rdata=0, ext_rvalid=0.
- REQ-025: During reset, combinational outputs still follow REQ-014 to REQ-018 with the state treated as IDLE.
- REQ-026: Reset asserted mid-lock or mid-read discards the pending ext_rvalid.

Configuration
- REQ-027: Macro DMEM_ARB_STARVE_GUARD_EN defined: a counter of width clog2(STARVE_LIMIT+1) increments each cycle ext_req=1 without an ext grant, and saturates at STARVE_LIMIT.
- REQ-028: Under DMEM_ARB_STARVE_GUARD_EN, counter==STARVE_LIMIT is the forced-starve condition. The counter clears on any ext grant or when ext_req=0.
- REQ-029: Macro undefined: no counter exists, the forced-starve condition is constant 0, and the cpu has strict priority, so ext may starve indefinitely.

Structure
- REQ-030: A shared package holds the owner-state enum (IDLE, CPU_OWN, EXT_OWN) and the default STARVE_LIMIT constant.
- REQ-031: One sub-module, dmem_arb_starve_cnt, contains the counter and its compare and is instantiated only under DMEM_ARB_STARVE_GUARD_EN.
- REQ-032: The top level integrates the block between the EX/MEM register outputs and dataMem, and ORs cpu_stall into the PC and pipeline-register write enables.

Verification
- REQ-033: Reset held 2 cycles -> state IDLE, ext_rvalid=0, ext_rdata=0, mem_we=0, mem_re=0.
- REQ-034: cpu_req=1, cpu_we=0, cpu_addr=0x10 and ext_req=1 in the same cycle -> cpu granted, cpu_stall=0, ext_gnt=0, mem_addr=0x10.
- REQ-035: ext read at 0x20 with cpu idle, memory word 0xDEADBEEF -> ext_gnt=1 in cycle N; ext_rvalid=1 and ext_rdata=0xDEADBEEF in cycle N+1.
- REQ-036: ext holds ext_lock=1 for 3 beats while cpu_req=1 -> cpu_stall=1 for exactly those 3 cycles, then the cpu is granted on the cycle ext_lock drops.
- REQ-037: With the guard enabled and STARVE_LIMIT=8, cpu_req and ext_req both held at 1 -> ext_gnt=1 on the 9th cycle with cpu_stall=1 that cycle, and the counter returns to 0.
- REQ-038: Macro undefined, same stimulus as REQ-037 for 100 cycles -> ext_gnt never asserts.
